// File: rtl/alu_pkg.sv
// alu_pkg: constants and types shared by the arbitrated ALU slice.
//   WORD_W  - datapath word width
//   FUNC_W  - ALU function code width (bit 3 = invert B / carry-in)
//   SHAMT_W - shift amount width
//   alu_op_e - F[2:0] operation encodings
//   state_e  - arbiter FSM state encoding
package alu_pkg;

  localparam int WORD_W  = 32;
  localparam int FUNC_W  = 4;
  localparam int SHAMT_W = 5;

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b010,
    OP_SLT = 3'b011,
    OP_SLL = 3'b100
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: request/response bundle between two requesters and the
// shared ALU arbiter.
//   req_valid/req_ready     - per-requester request handshake
//   req_a*/req_b*/req_f*/req_shamt* - operands per requester (0/1)
//   rsp_valid/rsp_ready     - per-requester response handshake
//   rsp_y, rsp_zero, rsp_ltez, rsp_err - shared registered result
//   busy                    - arbiter is not idle
// master = requester side, slave = arbiter side.
interface alu_arbiter_if;
  import alu_pkg::*;

  logic [1:0]         req_valid;
  logic [1:0]         req_ready;
  logic [WORD_W-1:0]  req_a0;
  logic [WORD_W-1:0]  req_a1;
  logic [WORD_W-1:0]  req_b0;
  logic [WORD_W-1:0]  req_b1;
  logic [FUNC_W-1:0]  req_f0;
  logic [FUNC_W-1:0]  req_f1;
  logic [SHAMT_W-1:0] req_shamt0;
  logic [SHAMT_W-1:0] req_shamt1;
  logic [1:0]         rsp_valid;
  logic [1:0]         rsp_ready;
  logic [WORD_W-1:0]  rsp_y;
  logic               rsp_zero;
  logic               rsp_ltez;
  logic               rsp_err;
  logic               busy;

  modport master (
    output req_valid, req_a0, req_a1, req_b0, req_b1, req_f0, req_f1,
           req_shamt0, req_shamt1, rsp_ready,
    input  req_ready, rsp_valid, rsp_y, rsp_zero, rsp_ltez, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_a0, req_a1, req_b0, req_b1, req_f0, req_f1,
           req_shamt0, req_shamt1, rsp_ready,
    output req_ready, rsp_valid, rsp_y, rsp_zero, rsp_ltez, rsp_err, busy
  );

endinterface

// File: rtl/alu.sv
// alu: combinational 32-bit ALU.
//   a, b   - operands
//   f      - function: f[3] inverts b and injects carry-in, f[2:0] selects op
//   shamt  - left shift amount for SLL
//   y      - result (0 for illegal codes)
//   zero   - y == 0 (legal codes only)
//   ltez   - zero | sign of the adder output (legal codes only)
//   err    - f[2:0] is not a defined operation
module alu
  import alu_pkg::*;
#(
  parameter int DATA_W = WORD_W
) (
  input  logic [DATA_W-1:0]  a,
  input  logic [DATA_W-1:0]  b,
  input  logic [FUNC_W-1:0]  f,
  input  logic [SHAMT_W-1:0] shamt,
  output logic [DATA_W-1:0]  y,
  output logic               zero,
  output logic               ltez,
  output logic               err
);

  logic [DATA_W-1:0]        bout;
  logic signed [DATA_W-1:0] sum;

  assign bout = f[3] ? ~b : b;
  // Wraps modulo 2^DATA_W; overflow is deliberately not reported.
  assign sum  = $signed(a + bout + {{(DATA_W-1){1'b0}}, f[3]});

  always_comb begin
    y    = '0;
    err  = 1'b0;
    zero = 1'b0;
    ltez = 1'b0;
    case (alu_op_e'(f[2:0]))
      OP_AND:  y = a & bout;
      OP_OR:   y = a | bout;
      OP_ADD:  y = sum;
      OP_SLT:  y = {{(DATA_W-1){1'b0}}, sum[DATA_W-1]};
      OP_SLL:  y = bout << shamt;
      default: err = 1'b1;
    endcase
    if (!err) begin
      zero = (y == '0);
      ltez = zero | sum[DATA_W-1];
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: two requesters share one ALU through a round-robin grant.
//   clk, reset - clock and synchronous active-high reset
//   bus        - alu_arbiter_if.slave request/response bundle
// Flow: IDLE grants one requester combinationally and latches its operands,
// EXEC evaluates the ALU and registers the result, RESP presents the result
// to the granted requester until it accepts. One operation in flight.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_W = WORD_W
) (
  input  logic         clk,
  input  logic         reset,
  alu_arbiter_if.slave bus
);

  state_e state_q, state_d;
  logic   ptr_q;
  logic   gnt_q, gnt_d;
  logic   fire;
  logic [1:0] req_ready;
  logic [1:0] rsp_valid;

  logic [DATA_W-1:0]  a_p0, b_p0;
  logic [FUNC_W-1:0]  f_p0;
  logic [SHAMT_W-1:0] shamt_p0;

  logic [DATA_W-1:0] alu_y;
  logic              alu_zero, alu_ltez, alu_err;

  logic [DATA_W-1:0] y_p1;
  logic              zero_p1, ltez_p1, err_p1;

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    fire      = 1'b0;
    req_ready = 2'b00;
    rsp_valid = 2'b00;
    case (state_q)
      ST_IDLE: begin
        // Gated by reset so nobody sees a handshake that is then dropped.
        if (!reset && (bus.req_valid != 2'b00)) begin
          gnt_d            = (bus.req_valid == 2'b11) ? ptr_q : bus.req_valid[1];
          req_ready[gnt_d] = 1'b1;
          fire             = 1'b1;
          state_d          = ST_EXEC;
        end
      end
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: begin
        rsp_valid[gnt_q] = 1'b1;
        if (bus.rsp_ready[gnt_q]) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= 1'b0;
      gnt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      // Round-robin pointer moves only when a response completes.
      if (state_q == ST_RESP && bus.rsp_ready[gnt_q]) ptr_q <= ~gnt_q;
    end
  end

  // Stage p0: operand latch of the granted requester
  always_ff @(posedge clk) begin
    if (fire) begin
      a_p0     <= gnt_d ? bus.req_a1     : bus.req_a0;
      b_p0     <= gnt_d ? bus.req_b1     : bus.req_b0;
      f_p0     <= gnt_d ? bus.req_f1     : bus.req_f0;
      shamt_p0 <= gnt_d ? bus.req_shamt1 : bus.req_shamt0;
    end
  end

  alu #(.DATA_W(DATA_W)) u_alu (
    .a     (a_p0),
    .b     (b_p0),
    .f     (f_p0),
    .shamt (shamt_p0),
    .y     (alu_y),
    .zero  (alu_zero),
    .ltez  (alu_ltez),
    .err   (alu_err)
  );

  // Stage p1: result registers, visible as outputs; cleared by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      y_p1    <= '0;
      zero_p1 <= 1'b0;
      ltez_p1 <= 1'b0;
      err_p1  <= 1'b0;
    end else if (state_q == ST_EXEC) begin
      y_p1    <= alu_y;
      zero_p1 <= alu_zero;
      ltez_p1 <= alu_ltez;
      err_p1  <= alu_err;
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_y     = y_p1;
  assign bus.rsp_zero  = zero_p1;
  assign bus.rsp_ltez  = ltez_p1;
  assign bus.rsp_err   = err_p1;
  assign bus.busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: table-driven vectors plus hand-written multi-cycle
// sequences; expected responses go into a scoreboard queue on grant and are
// compared by a monitor when the DUT completes a response.
module tb_alu_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_arbiter_if bus();

  alu_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int          idx;
    logic [31:0] y;
    logic        z;
    logic        l;
    logic        e;
    int          acc;
  } exp_t;

  typedef struct {
    int          who;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  f;
    logic [4:0]  sh;
    logic [31:0] y;
    logic        z;
    logic        l;
    logic        e;
  } vec_t;

  exp_t q[$];
  vec_t vecs[14];
  logic [1:0] prev_vld = 2'b00;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  function automatic void fail_now(input string nm);
    checks++;
    failures++;
    $display("FAIL %s: got timeout expected event", nm);
  endfunction

  function automatic void push_exp(input int who, input logic [31:0] y, input logic z, l, e);
    exp_t x;
    x.idx = who; x.y = y; x.z = z; x.l = l; x.e = e; x.acc = cyc;
    q.push_back(x);
  endfunction

  // Scoreboard monitor: latency/index on first valid, payload on completion.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.rsp_valid != 2'b00 && prev_vld == 2'b00) begin
        if (q.size() == 0) fail_now("unexpected_rsp");
        else begin
          chk("rsp_latency", cyc - q[0].acc, 2);
          chk("rsp_valid_idx", {30'd0, bus.rsp_valid}, (q[0].idx == 1) ? 32'd2 : 32'd1);
        end
      end
      if ((bus.rsp_valid & bus.rsp_ready) != 2'b00) begin
        if (q.size() == 0) fail_now("unexpected_done");
        else begin
          exp_t e;
          e = q.pop_front();
          chk("rsp_y",    bus.rsp_y, e.y);
          chk("rsp_zero", {31'd0, bus.rsp_zero}, {31'd0, e.z});
          chk("rsp_ltez", {31'd0, bus.rsp_ltez}, {31'd0, e.l});
          chk("rsp_err",  {31'd0, bus.rsp_err},  {31'd0, e.e});
        end
      end
    end
    prev_vld = bus.rsp_valid;
  end

  task automatic set_op(input int who, input logic [31:0] a, b, input logic [3:0] f, input logic [4:0] sh);
    if (who == 0) begin
      bus.req_a0 = a; bus.req_b0 = b; bus.req_f0 = f; bus.req_shamt0 = sh;
    end else begin
      bus.req_a1 = a; bus.req_b1 = b; bus.req_f1 = f; bus.req_shamt1 = sh;
    end
  endtask

  // Returns at the negedge of the grant cycle.
  task automatic wait_grant(input int who, input bit push, input logic [31:0] y, input logic z, l, e);
    int n;
    n = 0;
    @(negedge clk);
    while (bus.req_ready[who] !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) fail_now("grant_timeout");
    else begin
      chk("grant_onehot", {30'd0, bus.req_ready}, (who == 1) ? 32'd2 : 32'd1);
      if (push) push_exp(who, y, z, l, e);
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      fail_now("drain_timeout");
      q.delete();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, {30'd0, bus.req_ready}, 32'd0);
    chk({tag, "_rsp_valid"}, {30'd0, bus.rsp_valid}, 32'd0);
    chk({tag, "_rsp_y"},     bus.rsp_y, 32'd0);
    chk({tag, "_flags"},     {29'd0, bus.rsp_zero, bus.rsp_ltez, bus.rsp_err}, 32'd0);
    chk({tag, "_busy"},      {31'd0, bus.busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    vecs[0]  = '{0, 32'h00000005, 32'h00000003, 4'b0010, 5'd0,  32'h00000008, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1, 32'h00000003, 32'h00000003, 4'b1010, 5'd0,  32'h00000000, 1'b1, 1'b1, 1'b0};
    vecs[2]  = '{0, 32'hFFFFFFFF, 32'h00000001, 4'b1011, 5'd0,  32'h00000001, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{1, 32'h80000000, 32'h00000001, 4'b0100, 5'd31, 32'h80000000, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{0, 32'h00000001, 32'h00000002, 4'b0111, 5'd0,  32'h00000000, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{0, 32'h0000000A, 32'h00000007, 4'b1010, 5'd0,  32'h00000003, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1, 32'hF0F0F0F0, 32'hFF00FF00, 4'b0000, 5'd0,  32'hF000F000, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{0, 32'h0F0F0000, 32'h000000F0, 4'b0001, 5'd0,  32'h0F0F00F0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1, 32'h00000005, 32'h00000005, 4'b1000, 5'd0,  32'h00000000, 1'b1, 1'b1, 1'b0};
    vecs[9]  = '{0, 32'h00000002, 32'h00000005, 4'b1011, 5'd0,  32'h00000001, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{0, 32'h00000007, 32'h00000003, 4'b0011, 5'd0,  32'h00000000, 1'b1, 1'b1, 1'b0};
    vecs[11] = '{1, 32'h00000004, 32'h00000004, 4'b1101, 5'd0,  32'h00000000, 1'b0, 1'b0, 1'b1};
    vecs[12] = '{0, 32'h7FFFFFFF, 32'h00000001, 4'b0010, 5'd0,  32'h80000000, 1'b0, 1'b1, 1'b0};
    vecs[13] = '{1, 32'h00000000, 32'h00000003, 4'b1100, 5'd4,  32'hFFFFFFC0, 1'b0, 1'b1, 1'b0};

    bus.req_valid = 2'b11;
    bus.rsp_ready = 2'b00;
    set_op(0, 32'd0, 32'd0, 4'd0, 5'd0);
    set_op(1, 32'd0, 32'd0, 4'd0, 5'd0);

    // Reset state, with requests pending to show req_ready is held low.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    reset = 1'b0;
    bus.rsp_ready = 2'b11;
    @(negedge clk);
    check_reset_outputs("post_reset");

    // Table-driven single requests.
    for (int i = 0; i < 14; i++) begin
      @(posedge clk); #1;
      set_op(vecs[i].who, vecs[i].a, vecs[i].b, vecs[i].f, vecs[i].sh);
      bus.req_valid[vecs[i].who] = 1'b1;
      wait_grant(vecs[i].who, 1'b1, vecs[i].y, vecs[i].z, vecs[i].l, vecs[i].e);
      @(posedge clk); #1;
      bus.req_valid = 2'b00;
      wait_drain();
    end

    // Round-robin: fresh reset favours requester 0, then alternates.
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    set_op(0, 32'd5, 32'd3, 4'b0010, 5'd0);
    set_op(1, 32'd3, 32'd3, 4'b1010, 5'd0);
    bus.req_valid = 2'b11;
    wait_grant(0, 1'b1, 32'd8, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    set_op(0, 32'd9, 32'd4, 4'b1010, 5'd0);
    @(negedge clk);
    chk("rr_no_ready_exec", {30'd0, bus.req_ready}, 32'd0);
    wait_grant(1, 1'b1, 32'd0, 1'b1, 1'b1, 1'b0);
    @(posedge clk); #1;
    set_op(1, 32'd1, 32'd1, 4'b0001, 5'd0);
    wait_grant(0, 1'b1, 32'd5, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    bus.req_valid = 2'b10;
    wait_grant(1, 1'b1, 32'd1, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    wait_drain();

    // Backpressure: result held 10 cycles, stray rsp_ready[1] ignored.
    @(posedge clk); #1;
    bus.rsp_ready = 2'b00;
    set_op(0, 32'h12345678, 32'h11111111, 4'b0010, 5'd0);
    bus.req_valid = 2'b01;
    wait_grant(0, 1'b1, 32'h23456789, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    set_op(1, 32'h00000040, 32'h00000002, 4'b0001, 5'd0);
    bus.req_valid = 2'b10;
    bus.rsp_ready = 2'b10;
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      chk("bp_rsp_valid", {30'd0, bus.rsp_valid}, 32'd1);
      chk("bp_rsp_y",     bus.rsp_y, 32'h23456789);
      chk("bp_req_ready", {30'd0, bus.req_ready}, 32'd0);
      chk("bp_busy",      {31'd0, bus.busy}, 32'd1);
      @(negedge clk);
    end
    @(posedge clk); #1;
    bus.rsp_ready = 2'b11;
    @(negedge clk);
    c0 = cyc;
    chk("bp_done_valid", {30'd0, bus.rsp_valid}, 32'd1);
    wait_grant(1, 1'b1, 32'h00000042, 1'b0, 1'b0, 1'b0);
    chk("bp_regrant_cycle", cyc - c0, 1);
    chk("bp_idle_busy", {31'd0, bus.busy}, 32'd0);
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    wait_drain();

    // Reset during EXEC discards the operation; next request taken at once.
    @(posedge clk); #1;
    set_op(0, 32'd1, 32'd1, 4'b0010, 5'd0);
    bus.req_valid = 2'b01;
    wait_grant(0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    reset = 1'b1;
    @(negedge clk);
    chk("rst_exec_busy", {31'd0, bus.busy}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("rst_exec");
    @(posedge clk); #1;
    set_op(0, 32'd6, 32'd2, 4'b1010, 5'd0);
    bus.req_valid = 2'b01;
    @(negedge clk);
    chk("rst_fresh_ready", {30'd0, bus.req_ready}, 32'd1);
    push_exp(0, 32'd4, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    wait_drain();

    repeat (4) @(negedge clk);
    chk("final_queue_empty", q.size(), 0);
    chk("final_idle", {31'd0, bus.busy}, 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 req_valid[1:0]  input  2  per-requester operation request.
REQ-004 req_ready[1:0]  output  2  per-requester accept; transfer occurs when req_valid[i] & req_ready[i].
REQ-005 req_a0, req_a1  input  32 each  operand A, requester 0/1.
REQ-006 req_b0, req_b1  input  32 each  operand B, requester 0/1.
REQ-007 req_f0, req_f1  input  4 each  ALU function code, requester 0/1.
REQ-008 req_shamt0, req_shamt1  input  5 each  shift amount for SLL, requester 0/1.
REQ-009 rsp_valid[1:0]  output  2  per-requester result valid.
REQ-010 rsp_ready[1:0]  input  2  per-requester result accept.
REQ-011 rsp_y  output  32  registered result word, shared by both requesters.
REQ-012 rsp_zero, rsp_ltez, rsp_err  output  1 each  registered Zero flag, less-than-or-equal-zero flag, and illegal-function flag.
REQ-013 busy  output  1  high in any state other than IDLE.

Function
REQ-014 FSM states: IDLE, EXEC, RESP.
REQ-015 IDLE: if any req_valid is high, assert req_ready for exactly one granted requester in the same cycle (combinational), latch its A/B/F/shamt, record the grant index, and move to EXEC; otherwise stay in IDLE.
REQ-016 Grant: a single valid requester wins; if both are valid, the requester selected by a 1-bit round-robin pointer wins.
REQ-017 Pointer: updates on response completion to point at the requester not just served; reset value is 0 (requester 0 favoured).
REQ-018 EXEC: drive the shared ALU from the latched operands for one cycle, capture Y, Zero and ltez into the result registers, and move to RESP.
REQ-019 Functions: F[3] inverts B and supplies carry-in; F[2:0] encodes 000 AND, 001 OR, 010 ADD/SUB, 011 SLT (bit 31 of the sum), 100 SLL of Bout by shamt.
REQ-020 F[2:0] in 101..111: rsp_err=1, rsp_y=0, rsp_zero=0, rsp_ltez=0; X values are never propagated.
REQ-021 For legal functions, rsp_err=0, rsp_zero=(Y==0), rsp_ltez=rsp_zero|S[31]; the sum wraps modulo 2^32 and no overflow is flagged.
REQ-022 RESP: assert rsp_valid only for the granted index; hold rsp_y and the flags stable until rsp_ready is high for that index, then return to IDLE.
REQ-023 Latency: request accepted at cycle T gives rsp_valid at T+2; minimum spacing between accepts is 3 cycles.
REQ-024 The block never asserts req_ready in EXEC or RESP; requests arriving in those states wait.
REQ-025 The block ignores rsp_ready for the non-granted index and any rsp_ready that arrives outside RESP.
REQ-026 A request that drops req_valid before grant is not served; no state change results.

Reset
REQ-027 Reset returns the block to IDLE with pointer=0, req_ready=0, rsp_valid=0, rsp_y=0, rsp_zero=0, rsp_ltez=0, rsp_err=0 and busy=0.
REQ-028 Reset asserted in EXEC or RESP discards the in-flight operation; no response is issued for it.

Structure
REQ-029 Shared package alu_pkg holds the F[2:0] encodings, the FSM state encoding and the 32-bit word width constant.
REQ-030 One sub-module: the existing 32-bit ALU, named alu, instantiated once and fed only from the latched operand registers.

Verification
REQ-031 Single request: requester 0 sends A=5, B=3, F=0010 -> accepted at T, rsp_valid[0] at T+2, rsp_y=8, rsp_zero=0, rsp_err=0.
REQ-032 Simultaneous request after reset: both requesters valid, with requester 1 sending A=3, B=3, F=1010 -> requester 0 is served first, then requester 1 gets rsp_y=0, rsp_zero=1 and rsp_ltez=1; the next simultaneous pair favours requester 0 again only after requester 1 has been served.
REQ-033 SLT and SLL: A=0xFFFFFFFF, B=1, F=1011 -> rsp_y=1; B=0x1, shamt=31, F=0100 -> rsp_y=0x80000000, rsp_ltez=1.
REQ-034 Illegal function: F=0111 -> rsp_err=1, rsp_y=0, and the next request executes normally.
REQ-035 Backpressure: rsp_ready held low for 10 cycles -> rsp_valid and rsp_y stay constant, req_ready stays 0 and busy stays 1; completion follows in the cycle rsp_ready rises.
REQ-036 Reset in EXEC: reset pulsed in cycle T+1 -> no rsp_valid, all outputs at reset values, and a fresh request is accepted in the first cycle after reset.
